instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage for the single-issue MIPS-style core. Holds the program counter, drives the word address into the combinational instruction ROM, and captures the returned word plus PC+1 into the IF/ID pipeline register consumed by decode. Accepts stall from the hazard unit and PC redirect/flush from execute.

## Interface
- `N`, 32: instruction and datapath width.
- `ADDR_W`, 5: PC width; word-addressed, matches ROM depth 2^ADDR_W.
- `RESET_PC`, 0: PC value loaded on reset.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold PC and IF/ID contents this cycle.
- `redirect_valid`  in  1  execute resolved a taken branch/jump; load `redirect_pc`, flush IF/ID.
- `redirect_pc`  in  ADDR_W  redirect target (word index).
- `imem_addr`  out  ADDR_W  word address to the instruction ROM; equals current PC.
- `imem_instr`  in  N  instruction word returned combinationally by the ROM.
- `ifid_valid`  out  1  IF/ID register holds a live instruction.
- `ifid_instr`  out  N  latched instruction.
- `ifid_pc1`  out  ADDR_W  latched PC+1 of that instruction.
- `ifid_pred_taken`  out  1  fetch predicted this instruction taken (0 when prediction compiled out).

## Operation
- One clock; one asynchronous, active-low reset `rst_n`. Reset is asserted asynchronously and released synchronously to `clk` by the reset generator.
- Reset values: PC=`RESET_PC`, `ifid_valid`=0, `ifid_instr`=0, `ifid_pc1`=0, `ifid_pred_taken`=0.
- `imem_addr` = PC, combinationally; no other logic on this path.
- Next-PC priority per edge: redirect > stall > prediction > PC+1.
  - `redirect_valid`: PC←`redirect_pc`; IF/ID `valid`←0, `instr`←0, `pred_taken`←0. This overrides `stall`.
  - `stall` (no redirect): PC and all IF/ID fields hold.
  - Otherwise: IF/ID←{1, `imem_instr`, PC+1, pred}; PC←predicted target if pred else PC+1.
- PC arithmetic is modulo 2^ADDR_W: PC=2^ADDR_W−1 wraps to 0. The branch target is PC+1+offset[ADDR_W−1:0], also modulo 2^ADDR_W.
- Reset mid-stall or mid-redirect: reset wins immediately and asynchronously.

## Timing
- ROM read is combinational; fetch-to-IF/ID latency is 1 cycle.
- A redirect asserted in cycle t fetches the target in t+1. The IF/ID bubble from the flush is visible in t+1.
- A stall held for k cycles freezes the outputs for exactly k edges.
- Steady state: one instruction per cycle with no bubbles.
- The first valid IF/ID word appears on the first rising edge after reset release.

## Configuration
- `FETCH_STATIC_PREDICT_EN` defined: fetch predecodes `beq` (opcode 6'b000100). If offset `imem_instr[15]`=1 (backward), it predicts taken. PC←PC+1+`imem_instr[ADDR_W−1:0]` and `ifid_pred_taken`=1. Execute must redirect to the fall-through address on a mispredict.
- Not defined: no predecode; PC←PC+1 always; `ifid_pred_taken` tied 0.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants (`OP_RTYPE`=0, `OP_BEQ`=4, `OP_LW`=35, `OP_SW`=43);
  - `ADDR_W` and `RESET_PC` defaults;
  - IF/ID bundle typedef {valid, instr, pc1, pred_taken}.
- One natural sub-module, `fetch_predecode`: combinational; takes instr and PC+1 and returns {pred_taken, target}. Instantiated only under `FETCH_STATIC_PREDICT_EN`.

## Test plan
- Reset with ROM words 0..5 loaded, release, 6 free-running cycles -> `imem_addr` 0,1,2,3,4,5; `ifid_pc1` 1..6; `ifid_valid`=1 from the first edge.
- `stall`=1 for 3 cycles at PC=2 -> `imem_addr` stays 2; IF/ID holds word 1 (`ifid_pc1`=2) for 3 edges; resumes at 3.
- `redirect_valid`=1, `redirect_pc`=4 while PC=2 -> next `imem_addr`=4; `ifid_valid`=0 for one cycle; then word 4 with `ifid_pc1`=5.
- `redirect_valid` and `stall` both 1, `redirect_pc`=0 -> PC=0 and IF/ID flushed (redirect wins).
- PC=31 (ADDR_W=5) unstalled -> next PC=0; `ifid_pc1`=0.
- `FETCH_STATIC_PREDICT_EN`: `beq` at PC=5 with offset −3 -> next `imem_addr`=3, `ifid_pred_taken`=1. Forward `beq` offset +1 -> PC=6, `ifid_pred_taken`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core definitions: opcodes, fetch defaults and the IF/ID bundle.
package cpu_pkg;

    localparam int N_DEF        = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int RESET_PC_DEF = 0;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef struct packed {
        logic                  valid;
        logic [N_DEF-1:0]      instr;
        logic [ADDR_W_DEF-1:0] pc1;
        logic                  pred_taken;
    } ifid_t;

endpackage

// File: rtl/fetch_predecode.sv
// Static backward-beq predictor: flags backward beq as taken and forms its target.
// Purely combinational; target is PC+1+offset modulo 2^ADDR_W.
module fetch_predecode
    import cpu_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [N-1:0]      instr,
    input  logic [ADDR_W-1:0] pc1,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] target
);

    // Only opcode, offset sign and the low offset bits matter here.
    logic unused_instr;
    assign unused_instr = ^instr;

    assign pred_taken = (instr[31:26] == OP_BEQ) && instr[15];
    assign target     = pc1 + instr[ADDR_W-1:0];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, combinational ROM address, IF/ID register (1-cycle latency).
// Redirect beats stall; stall freezes PC and IF/ID. FETCH_STATIC_PREDICT_EN enables beq predecode.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [N-1:0]      imem_instr,
    output logic              ifid_valid,
    output logic [N-1:0]      ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc1,
    output logic              ifid_pred_taken
);

    typedef struct packed {
        logic              valid;
        logic [N-1:0]      instr;
        logic [ADDR_W-1:0] pc1;
        logic              pred_taken;
    } ifid_reg_t;

    localparam logic [ADDR_W-1:0] RESET_PC_W = RESET_PC[ADDR_W-1:0];

    logic [ADDR_W-1:0] pc_q, pc_d;
    ifid_reg_t         ifid_q, ifid_d;
    logic [ADDR_W-1:0] pc_plus1;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;

    assign pc_plus1 = pc_q + 1'b1;

`ifdef FETCH_STATIC_PREDICT_EN
    fetch_predecode #(
        .N      (N),
        .ADDR_W (ADDR_W)
    ) u_predecode (
        .instr      (imem_instr),
        .pc1        (pc_plus1),
        .pred_taken (pred_taken),
        .target     (pred_target)
    );
`else
    assign pred_taken  = 1'b0;
    assign pred_target = pc_plus1;
`endif

    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        if (redirect_valid) begin
            // Flush leaves a bubble; the target is fetched next cycle.
            pc_d   = redirect_pc;
            ifid_d = '0;
        end else if (!stall) begin
            ifid_d.valid      = 1'b1;
            ifid_d.instr      = imem_instr;
            ifid_d.pc1        = pc_plus1;
            ifid_d.pred_taken = pred_taken;
            pc_d              = pred_taken ? pred_target : pc_plus1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC_W;
            ifid_q <= '0;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
        end
    end

    assign imem_addr       = pc_q;
    assign ifid_valid      = ifid_q.valid;
    assign ifid_instr      = ifid_q.instr;
    assign ifid_pc1        = ifid_q.pc1;
    assign ifid_pred_taken = ifid_q.pred_taken;

endmodule
